// File: rtl/lemmings_pkg.sv
// Shared types for the Lemmings walker/world pair: FSM state enum and width helper.
package lemmings_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      WAIT_L = 2'd1,
      WAIT_R = 2'd2
   } state_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int pw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lemmings_step_timer.sv
// Step prescaler (tick every STEP_DIV enabled cycles) and turn-timeout counter.
module lemmings_step_timer
   import lemmings_pkg::*;
#(
   parameter int STEP_DIV     = 4,
   parameter int TURN_TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pre_en,
   input  logic pre_clr,
   input  logic tmo_en,
   input  logic tmo_clr,
   output logic tick,
   output logic tmo_done
);

   localparam int CW = pw(STEP_DIV);
   localparam int TW = pw(TURN_TIMEOUT);
   localparam logic [CW-1:0] PRE_LAST = CW'(STEP_DIV - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TURN_TIMEOUT - 1);

   logic [CW-1:0] pre_q, pre_d;
   logic [TW-1:0] tmo_q, tmo_d;

   assign tick     = pre_en && (pre_q == PRE_LAST);
   assign tmo_done = tmo_en && (tmo_q == TMO_LAST);

   always_comb begin
      pre_d = pre_q;
      tmo_d = tmo_q;
      if (pre_clr)     pre_d = '0;
      else if (pre_en) pre_d = tick ? '0 : pre_q + CW'(1);
      if (tmo_clr)                  tmo_d = '0;
      else if (tmo_en && !tmo_done) tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         tmo_q <= '0;
      end else begin
         pre_q <= pre_d;
         tmo_q <= tmo_d;
      end
   end

endmodule

// File: rtl/lemmings_world.sv
// 1-D track environment closing the loop around the Lemmings walker FSM.
// Optional obstacle register enabled by defining LEMMINGS_WORLD_OBSTACLE_EN.
module lemmings_world
   import lemmings_pkg::*;
#(
   parameter int TRACK_LEN    = 16,
   parameter int STEP_DIV     = 4,
   parameter int START_POS    = 8,
   parameter int TURN_TIMEOUT = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       walk_left,
   input  logic                       walk_right,
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
   input  logic                       obs_load,
   input  logic                       obs_clr,
   input  logic [pw(TRACK_LEN)-1:0]   obs_pos,
`endif
   output logic                       bump_left,
   output logic                       bump_right,
   output logic [pw(TRACK_LEN)-1:0]   pos,
   output logic                       step,
   output logic                       err
);

   localparam int PW = pw(TRACK_LEN);
   localparam logic [PW-1:0] POS_MAX = PW'(TRACK_LEN - 1);
   localparam logic [PW-1:0] POS_RST = PW'(START_POS);

   state_e        state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          bump_left_q, bump_left_d, bump_right_q, bump_right_d;
   logic          step_q, step_d, err_q, err_d;
   logic          tick, tmo_done, pre_en, pre_clr, tmo_en, tmo_clr;
   logic [PW-1:0] pos_m1, pos_p1;
   logic          blocked_l, blocked_r;

   assign pos_m1 = pos_q - PW'(1);
   assign pos_p1 = pos_q + PW'(1);

`ifdef LEMMINGS_WORLD_OBSTACLE_EN
   logic [PW-1:0] obs_q, obs_d;
   logic          obs_vld_q, obs_vld_d;

   // Ticks compare against the registered obstacle, so same-cycle loads/clears apply afterwards.
   assign blocked_l = obs_vld_q && (pos_m1 == obs_q);
   assign blocked_r = obs_vld_q && (pos_p1 == obs_q);

   always_comb begin
      obs_d     = obs_q;
      obs_vld_d = obs_vld_q;
      if (obs_clr) begin
         obs_vld_d = 1'b0;
      end else if (obs_load && (obs_pos != pos_q) && (32'(obs_pos) < TRACK_LEN)) begin
         obs_d     = obs_pos;
         obs_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obs_q     <= '0;
         obs_vld_q <= 1'b0;
      end else begin
         obs_q     <= obs_d;
         obs_vld_q <= obs_vld_d;
      end
   end
`else
   assign blocked_l = 1'b0;
   assign blocked_r = 1'b0;
`endif

   lemmings_step_timer #(
      .STEP_DIV     (STEP_DIV),
      .TURN_TIMEOUT (TURN_TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .pre_en   (pre_en),
      .pre_clr  (pre_clr),
      .tmo_en   (tmo_en),
      .tmo_clr  (tmo_clr),
      .tick     (tick),
      .tmo_done (tmo_done)
   );

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      bump_left_d  = 1'b0;
      bump_right_d = 1'b0;
      step_d       = 1'b0;
      err_d        = err_q;
      pre_en       = 1'b0;
      pre_clr      = 1'b0;
      tmo_en       = 1'b0;
      tmo_clr      = 1'b0;
      unique case (state_q)
         RUN: begin
            pre_en  = 1'b1;
            tmo_clr = 1'b1;
            if (tick) begin
               if (walk_left && !walk_right) begin
                  if (pos_q == '0 || blocked_l) begin
                     bump_left_d = 1'b1;
                     state_d     = WAIT_L;
                  end else begin
                     pos_d  = pos_m1;
                     step_d = 1'b1;
                  end
               end else if (walk_right && !walk_left) begin
                  if (pos_q == POS_MAX || blocked_r) begin
                     bump_right_d = 1'b1;
                     state_d      = WAIT_R;
                  end else begin
                     pos_d  = pos_p1;
                     step_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WAIT_L: begin
            pre_clr = 1'b1;
            tmo_en  = 1'b1;
            if (walk_right && !walk_left) begin
               state_d = RUN;
            end else if (tmo_done) begin
               err_d   = 1'b1;
               state_d = RUN;
            end
         end
         WAIT_R: begin
            pre_clr = 1'b1;
            tmo_en  = 1'b1;
            if (walk_left && !walk_right) begin
               state_d = RUN;
            end else if (tmo_done) begin
               err_d   = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pos_q        <= POS_RST;
         bump_left_q  <= 1'b0;
         bump_right_q <= 1'b0;
         step_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         bump_left_q  <= bump_left_d;
         bump_right_q <= bump_right_d;
         step_q       <= step_d;
         err_q        <= err_d;
      end
   end

   assign bump_left  = bump_left_q;
   assign bump_right = bump_right_q;
   assign pos        = pos_q;
   assign step       = step_q;
   assign err        = err_q;

endmodule

// File: tb/tb_lemmings_world.sv
// Bench for lemmings_world: closed loop with a behavioural walker plus open-loop and random phases.
module tb_lemmings_world;
   import lemmings_pkg::*;

   localparam int TL = 8;
   localparam int SD = 2;
   localparam int SP = 3;
   localparam int TT = 8;
   localparam int PW = pw(TL);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          walk_left = 1'b0;
   logic          walk_right = 1'b0;
   logic          bump_left, bump_right, step, err;
   logic [PW-1:0] pos;
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
   logic          obs_load = 1'b0;
   logic          obs_clr = 1'b0;
   logic [PW-1:0] obs_pos = '0;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 = stepping, 1 = waiting after left wall, 2 = after right wall.
   int m_pos, m_cnt, m_mode, m_wait, m_obs;
   bit m_bl, m_br, m_step, m_err, m_obs_v;
   bit w_right;

   always #5 clk = ~clk;

   lemmings_world #(
      .TRACK_LEN    (TL),
      .STEP_DIV     (SD),
      .START_POS    (SP),
      .TURN_TIMEOUT (TT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .walk_left  (walk_left),
      .walk_right (walk_right),
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
      .obs_load   (obs_load),
      .obs_clr    (obs_clr),
      .obs_pos    (obs_pos),
`endif
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .pos        (pos),
      .step       (step),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pos", 32'(pos), m_pos);
      chk("step", 32'(step), 32'(m_step));
      chk("bump_left", 32'(bump_left), 32'(m_bl));
      chk("bump_right", 32'(bump_right), 32'(m_br));
      chk("err", 32'(err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_pos = SP; m_cnt = 0; m_mode = 0; m_wait = 0; m_obs = 0;
      m_bl = 0; m_br = 0; m_step = 0; m_err = 0; m_obs_v = 0;
      w_right = 0;
   endtask

   task automatic model_step(input bit wl, input bit wr);
      int tgt;
      int pre_pos;
      pre_pos = m_pos;
      m_bl = 0; m_br = 0; m_step = 0;
      if (m_mode == 0) begin
         if (m_cnt == SD - 1) begin
            m_cnt = 0;
            if (wl != wr) begin
               tgt = wl ? m_pos - 1 : m_pos + 1;
               if (tgt < 0 || tgt > TL - 1 || (m_obs_v && tgt == m_obs)) begin
                  if (wl) begin m_bl = 1; m_mode = 1; end
                  else    begin m_br = 1; m_mode = 2; end
                  m_wait = 0;
               end else begin
                  m_pos = tgt;
                  m_step = 1;
               end
            end else begin
               m_err = 1;
            end
         end else begin
            m_cnt++;
         end
      end else begin
         if ((m_mode == 1 && wr && !wl) || (m_mode == 2 && wl && !wr)) begin
            m_mode = 0; m_cnt = 0;
         end else begin
            m_wait++;
            if (m_wait == TT) begin m_err = 1; m_mode = 0; m_cnt = 0; end
         end
      end
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
      if (obs_clr) m_obs_v = 0;
      else if (obs_load && int'(obs_pos) != pre_pos && int'(obs_pos) < TL) begin
         m_obs = int'(obs_pos); m_obs_v = 1;
      end
`endif
   endtask

   task automatic cycle(input bit wl, input bit wr);
      walk_left = wl;
      walk_right = wr;
      @(posedge clk);
      model_step(wl, wr);
      @(negedge clk);
      check_all();
   endtask

   // Walker reverses on the edge after it sees a bump pulse.
   task automatic walker_cycle();
      bit fl, fr;
      fl = m_bl;
      fr = m_br;
      cycle(!w_right, w_right);
      if (fl) w_right = 1;
      if (fr) w_right = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int bl_n, br_n, min_p, max_p, nb, lat, bump_at;
      bit seen;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Closed loop: left to the wall, turn, right to the wall.
      bl_n = 0; br_n = 0; min_p = SP; max_p = SP;
      for (int i = 0; i < 80; i++) begin
         walker_cycle();
         if (bump_left) bl_n++;
         if (bump_right) br_n++;
         if (int'(pos) < min_p) min_p = int'(pos);
         if (int'(pos) > max_p) max_p = int'(pos);
         if (m_br) break;
      end
      chk("loop_bump_left_count", bl_n, 1);
      chk("loop_bump_right_count", br_n, 1);
      chk("loop_min_pos", min_p, 0);
      chk("loop_max_pos", max_p, TL - 1);

      // Reset lands during the bump_right pulse.
      do_reset();

      // Both walk inputs high at a tick: sticky err, pos held.
      cycle(1, 1);
      cycle(1, 1);
      chk("both_err", 32'(err), 1);
      chk("both_pos", 32'(pos), SP);
      for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("err_sticky", 32'(err), 1);
      do_reset();

      // Left held with no turn: one bump, timeout err 8 cycles later.
      nb = 0; lat = 0; seen = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0);
         if (seen) lat++;
         if (bump_left) begin nb++; seen = 1; end
         if (err) break;
      end
      chk("timeout_bumps", nb, 1);
      chk("timeout_latency", lat, TT);
      do_reset();

      // Random open-loop stimulus, mostly one-hot walk inputs, occasional resets.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
         obs_load = ($urandom_range(0, 9) == 0);
         obs_clr  = ($urandom_range(0, 19) == 0);
         obs_pos  = PW'($urandom_range(0, TL - 1));
`endif
         if (r < 2) begin
            do_reset();
         end else if (r < 8) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            bit d;
            d = 1'($urandom_range(0, 1));
            cycle(d, !d);
         end
      end
`ifdef LEMMINGS_WORLD_OBSTACLE_EN
      obs_load = 0; obs_clr = 0;
      do_reset();

      // Obstacle at 1 stops the left run at 2; after clearing, the left run reaches 0.
      obs_load = 1; obs_pos = PW'(1);
      walker_cycle();
      obs_load = 0;
      bump_at = -1;
      for (int i = 0; i < 20; i++) begin
         walker_cycle();
         if (bump_left) begin bump_at = int'(pos); break; end
      end
      chk("obs_bump_pos", bump_at, 2);
      obs_clr = 1;
      walker_cycle();
      obs_clr = 0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         walker_cycle();
         if (pos == '0) begin seen = 1; break; end
      end
      chk("obs_cleared_reach0", 32'(seen), 1);
      do_reset();

      // Load at the current position is ignored: first bump only at the wall.
      obs_load = 1; obs_pos = PW'(SP);
      walker_cycle();
      obs_load = 0;
      bump_at = -1;
      for (int i = 0; i < 30; i++) begin
         walker_cycle();
         if (bump_left) begin bump_at = int'(pos); break; end
      end
      chk("obs_self_ignored", bump_at, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lemmings_world.md
# lemmings_world

Environment model for the Lemmings walker FSM: owns the lemming's position on a 1-D track, consumes `walk_left`/`walk_right`, and drives `bump_left`/`bump_right` back into the walker. It is the counterpart of the walker FSM. Synthesizable and used both as a bench stimulus source and in on-board demos, where it sits beside the walker and closes its loop.

## Interface
- `TRACK_LEN`, 16: number of positions, 0..TRACK_LEN-1; must be ≥ 4.
- `STEP_DIV`, 4: clock cycles per lemming step; must be ≥ 2.
- `START_POS`, 8: position after reset; must be in 1..TRACK_LEN-2.
- `TURN_TIMEOUT`, 8: cycles allowed for the walker to reverse after a bump.
- `clk` in 1: clock. One clock, rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `walk_left` in 1: walker is moving left.
- `walk_right` in 1: walker is moving right.
- `bump_left` out 1: left wall hit, one-cycle pulse.
- `bump_right` out 1: right wall hit, one-cycle pulse.
- `pos` out PW = $clog2(TRACK_LEN): current position.
- `step` out 1: one-cycle pulse when `pos` changes.
- `err` out 1: sticky fault flag. Cleared only by reset.
- `obs_load` in 1 (`_OBSTACLE_EN` only): load obstacle position.
- `obs_clr` in 1 (`_OBSTACLE_EN` only): remove the obstacle.
- `obs_pos` in PW (`_OBSTACLE_EN` only): obstacle position to load.

## Operation
- FSM states:
  - RUN: stepping.
  - WAIT_L: bumped on the left; waiting for the walker to turn right.
  - WAIT_R: bumped on the right; waiting for the walker to turn left.
- Reset values: state RUN, `pos`=START_POS, prescaler=0, all outputs 0, no obstacle.
- Prescaler in RUN:
  - Counts 0..STEP_DIV-1 and wraps.
  - A tick occurs when the count is STEP_DIV-1.
- On a tick with exactly one walk input high:
  - `walk_left` high: the target is pos-1.
    - If pos=0, or the target equals an active obstacle: pulse `bump_left` and go to WAIT_L. `pos` is held.
    - Otherwise: `pos` ← pos-1 and pulse `step`.
  - `walk_right` high: mirror image of the above, with limit TRACK_LEN-1, `bump_right` and WAIT_R.
- On a tick with both walk inputs high, or neither: set `err` and hold `pos`. State stays RUN.
- Outside a tick, the walk inputs are ignored.
- WAIT_L:
  - Prescaler held at 0; timeout counter runs.
  - First cycle with `walk_right`=1 and `walk_left`=0: go to RUN and restart the prescaler from 0.
  - Timeout counter reaching TURN_TIMEOUT: set `err` and go to RUN.
- WAIT_R: mirror image of WAIT_L.
- A bump never repeats while in WAIT_x, so the walker sees exactly one edge per wall hit.
- `pos` never leaves 0..TRACK_LEN-1. Moves saturate by construction; there is no wrap-around.

## Timing
- `bump_*` and `step` are registered: asserted for exactly one cycle, in the cycle after the tick clock edge.
- A compliant walker reverses one cycle after seeing the bump, so WAIT_x normally lasts 1 cycle.
- Steady-state stepping period is STEP_DIV cycles.
- Between a bump and the next step: 1 (bump) + turn latency + STEP_DIV cycles.
- Reset asserted mid-operation returns everything to reset values immediately, including during a bump pulse.

## Configuration
- `LEMMINGS_WORLD_OBSTACLE_EN` defined:
  - Ports `obs_load`, `obs_clr`, `obs_pos` exist, with an internal obstacle register and valid bit.
  - `obs_load` when `obs_pos` is not equal to `pos` and is less than TRACK_LEN: obstacle ← `obs_pos`, valid ← 1.
  - `obs_load` is ignored if `obs_pos` equals the current `pos`, or if `obs_pos` ≥ TRACK_LEN.
  - `obs_clr` clears valid. If it coincides with `obs_load`, `obs_clr` wins.
  - If a tick coincides with a load or clear, the tick uses the pre-update obstacle.
- Not defined: the obstacle ports and logic are absent, and only the edge walls cause bumps.

## Structure
- Package `lemmings_pkg`:
  - State enum: RUN, WAIT_L, WAIT_R.
  - PW width function.
  - Shared with the walker bench.
- Sub-module `lemmings_step_timer`: the prescaler plus the timeout counter, with clear and enable controls. Everything else stays in the top module.

## Test plan
All scenarios use TRACK_LEN=8, STEP_DIV=2, START_POS=3, with the world looped to the walker FSM (which walks left from reset).
- Reset, then run freely:
  - `pos` goes 3→2→1→0, one step every 2 cycles.
  - Then `bump_left` is a single 1-cycle pulse.
  - The walker turns and `pos` climbs 1..7.
  - Then a single `bump_right` pulse.
  - `err`=0 throughout.
- Open loop, both walk inputs forced to 1 at a tick: `err`=1 and `pos` unchanged. `err` stays 1 until `rst_n` goes low.
- Open loop, `walk_left` held at 0 and 1 with `pos`=0: one `bump_left` pulse, then `err`=1 after 8 cycles with no retrigger.
- `rst_n` pulsed low in the same cycle as the `bump_right` pulse: all outputs are 0 immediately and `pos`=3.
- With OBSTACLE_EN, `obs_load`=1 and `obs_pos`=1 while `pos`=3, walking left:
  - `bump_left` pulses at `pos`=2.
  - Then `obs_clr` is applied, and the next left run reaches `pos`=0.
- With OBSTACLE_EN, `obs_load` with `obs_pos` equal to the current `pos`: the load is ignored and no bump is generated.
